// File: rtl/btn_debounce_pulse.sv
// Per-channel push-button debouncer: 2-flop synchronizer, stable-count qualifier and
// a 4-state FSM that emits a one-clock press strobe plus a registered debounced level.
module btn_debounce_pulse #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] pulse,
    output logic [N_BTN-1:0] level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitPress,
        StPressed,
        StWaitRelease
    } state_e;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pulse_q, pulse_d;
        logic             level_q, level_d;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
                level_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
                level_q <= level_d;
            end
        end

        // Any level change before the count completes restarts qualification from zero.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                StIdle: begin
                    if (sync2[i]) begin
                        state_d = StWaitPress;
                        cnt_d   = '0;
                    end
                end
                StWaitPress: begin
                    if (!sync2[i]) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = StPressed;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    if (!sync2[i]) begin
                        state_d = StWaitRelease;
                        cnt_d   = '0;
                    end
                end
                StWaitRelease: begin
                    if (sync2[i]) begin
                        state_d = StPressed;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are registered from the next state so level tracks the FSM exactly.
        always_comb begin
            pulse_d = (state_q == StWaitPress) && (state_d == StPressed);
            level_d = (state_d == StPressed) || (state_d == StWaitRelease);
        end

        assign pulse[i] = pulse_q;
        assign level[i] = level_q;
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse: stimulus pushes expected (cycle, mask) pulse
// events; an independent monitor pops and compares whenever any pulse bit is high.
module tb_btn_debounce_pulse;

    localparam int NB = 4;
    localparam int DC = 4;
    // Input driven at a falling edge is sampled by the next edge (edge 0); pulse appears
    // after edge DC+2, i.e. DC+3 rising edges after the driving point.
    localparam int LAT = DC + 3;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] pulse;
    logic [NB-1:0] level;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_pulse_events = 0;
    int   n_expected = 0;
    exp_t exp_q[$];

    btn_debounce_pulse #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .pulse  (pulse),
        .level  (level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int c, input logic [3:0] m);
        exp_t e;
        e.cyc  = c;
        e.mask = m;
        exp_q.push_back(e);
        n_expected++;
    endtask

    // Monitor: compares every observed pulse against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                exp_t m;
                m = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missed_pulse: expected mask %b at cycle %0d was not observed",
                         m.mask, m.cyc);
            end
            if (pulse != '0) begin
                n_pulse_events++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got mask %b at cycle %0d, expected none",
                             pulse, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_mask", int'(pulse), int'(e.mask));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int r;
        int d;
        logic pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_pulse", int'(pulse), 0);
        check("reset_level", int'(level), 0);
        reset = 1'b0;
        at(cyc + 3);

        // Clean press on ch0, held 30 cycles, then released
        c = cyc;
        btn_raw[0] = 1'b1;
        expect_pulse(c + LAT, 4'b0001);
        at(c + LAT - 1);
        check("clean_level_before", int'(level), 0);
        at(c + LAT);
        check("clean_level_after", int'(level), 1);
        at(c + 30);
        btn_raw[0] = 1'b0;
        r = cyc;
        at(r + 6);
        check("clean_release_hold", int'(level), 1);
        at(r + 7);
        check("clean_release_done", int'(level), 0);
        at(r + 12);

        // Press bounce on ch1
        for (int k = 0; k < 7; k++) begin
            btn_raw[1] = pat[k];
            @(negedge clk);
        end
        c = cyc;
        btn_raw[1] = 1'b1;
        expect_pulse(c + LAT, 4'b0010);
        at(c + 20);
        check("bounce_level", int'(level), 2);
        btn_raw[1] = 1'b0;
        at(cyc + 12);

        // Release bounce on ch0
        c = cyc;
        btn_raw[0] = 1'b1;
        expect_pulse(c + LAT, 4'b0001);
        at(c + 10);
        btn_raw[0] = 1'b0;
        repeat (2) @(negedge clk);
        btn_raw[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("relbounce_level_held", int'(level), 1);
        end
        btn_raw[0] = 1'b0;
        r = cyc;
        at(r + 6);
        check("relbounce_level_hold", int'(level), 1);
        at(r + 7);
        check("relbounce_level_drop", int'(level), 0);
        at(r + 12);

        // Simultaneous press on ch0 and ch2
        c = cyc;
        btn_raw = 4'b0101;
        expect_pulse(c + LAT, 4'b0101);
        at(c + LAT + 1);
        check("simul_level", int'(level), 5);
        btn_raw = '0;
        at(cyc + 12);

        // Reset during ch3 WAIT_PRESS with ch0 already pressed
        c = cyc;
        btn_raw[0] = 1'b1;
        expect_pulse(c + LAT, 4'b0001);
        at(c + LAT + 1);
        btn_raw[3] = 1'b1;
        c = cyc;
        at(c + 4);
        reset = 1'b1;
        btn_raw[0] = 1'b0;
        #1;
        check("midreset_level", int'(level), 0);
        check("midreset_pulse", int'(pulse), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        d = cyc;
        expect_pulse(d + LAT, 4'b1000);
        at(d + LAT - 1);
        check("postreset_level_before", int'(level), 0);
        at(d + LAT + 1);
        check("postreset_level_after", int'(level), 8);
        btn_raw[3] = 1'b0;
        at(cyc + 12);

        // Long hold on ch3, then release and re-press
        c = cyc;
        btn_raw[3] = 1'b1;
        expect_pulse(c + LAT, 4'b1000);
        at(c + 1000);
        check("longhold_level", int'(level), 8);
        btn_raw[3] = 1'b0;
        at(cyc + 12);
        c = cyc;
        btn_raw[3] = 1'b1;
        expect_pulse(c + LAT, 4'b1000);
        at(c + 20);
        btn_raw[3] = 1'b0;
        at(cyc + 12);

        check("scoreboard_empty", exp_q.size(), 0);
        check("pulse_event_count", n_pulse_events, n_expected);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce_pulse.md
BTN_DEBOUNCE_PULSE -- requirements
Module: btn_debounce_pulse

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- N_BTN, 4, number of independent button channels (LOAD_A1, LOAD_A2, LOAD_B1, LOAD_B2).
- DEBOUNCE_CYCLES, 500000, stable-sample count required to accept a level change (10 ms at 50 MHz); legal minimum 2.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, input, 1, single system clock; all state updates on its rising edge.
- reset, input, 1, asynchronous, active-high reset.
- btn_raw, input, N_BTN, raw asynchronous push-button levels; 1 = pressed.
- pulse, output, N_BTN, registered one-clock press strobe per channel; feeds the operand loader's load_a1/load_a2/load_b1/load_b2.
- level, output, N_BTN, registered debounced button level per channel.
REQ-003 The block SHALL use one clock (clk); reset SHALL be asynchronous and active-high.
REQ-004 Counter width SHALL be $clog2(DEBOUNCE_CYCLES) bits; no other parameter SHALL affect port widths.

Function
REQ-005 Each channel SHALL be fully independent: 2-flop synchronizer (sync1, sync2), counter, 4-state FSM, pulse and level registers.
REQ-006 FSM states per channel SHALL be IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
REQ-007 IDLE: sync2=1 -> WAIT_PRESS, cnt<=0; else remain.
REQ-008 WAIT_PRESS: sync2=0 -> IDLE, cnt<=0 (bounce rejected, no pulse); sync2=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1; sync2=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, pulse<=1.
REQ-009 PRESSED: sync2=0 -> WAIT_RELEASE, cnt<=0; else remain.
REQ-010 WAIT_RELEASE: sync2=1 -> PRESSED, no pulse; sync2=0 and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1; sync2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
REQ-011 pulse SHALL be high for exactly one cycle per accepted press and SHALL be cleared on the following edge regardless of input.
REQ-012 level SHALL be registered; it SHALL be 1 exactly while the FSM is in PRESSED or WAIT_RELEASE.
REQ-013 Latency: btn_raw first sampled high at edge 0 and held stable SHALL produce pulse=1 and level=1 in the cycle after edge DEBOUNCE_CYCLES+2.
REQ-014 Any sync2 change before the count completes SHALL restart qualification from cnt=0; the counter SHALL never wrap.
REQ-015 Holding a button indefinitely SHALL produce exactly one pulse; a new pulse requires passing through IDLE.
REQ-016 Simultaneous presses on several channels SHALL yield pulses in the same cycle; the block SHALL NOT prioritise or serialise.

Reset
REQ-017 While reset=1: all state SHALL be IDLE, and all of sync1, sync2, cnt, pulse and level SHALL be 0, asynchronously.
REQ-018 Reset asserted mid-operation SHALL discard the in-progress count and any pending pulse, with no pulse on or after deassertion from that press.
REQ-019 A button held through reset deassertion SHALL be treated as a new press: one pulse DEBOUNCE_CYCLES+2 edges after the first post-reset edge.

Verification (DEBOUNCE_CYCLES=4, N_BTN=4)
REQ-020 Clean press: btn_raw[0]=1 from edge 0, held 30 cycles -> pulse[0]=1 only in cycle after edge 6; level[0]=1 from edge 6; other channels stay 0.
REQ-021 Press bounce: btn_raw[1] pattern 1,1,0,1,1,1,0 then held 1 -> no pulse during bounce; single pulse[1] 6 edges after the final stable rise.
REQ-022 Release bounce: with ch0 in PRESSED, drive 0 for 2 cycles then 1 -> level[0] stays 1, no second pulse; then drive 0 stable -> level[0]=0 after 4 edges past sync2 falling.
REQ-023 Simultaneous: btn_raw[0] and btn_raw[2] rise on the same edge -> pulse[0] and pulse[2] high in the same single cycle.
REQ-024 Reset mid-op: assert reset during WAIT_PRESS -> pulse, level 0 immediately, no pulse; button held through deassertion -> exactly one pulse 6 edges after the first post-reset edge.
REQ-025 Long hold: btn_raw[3]=1 for 1000 cycles -> exactly one pulse[3]; release, re-press -> exactly one more.
